// File: rtl/test_pe_cfg_seq_if.sv
// Command / response channels between the tile config network and the sequencer.
`timescale 1ns/1ps
interface test_pe_cfg_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/test_pe_cfg_seq.sv
// PE config-bus sequencer: one write/read/write-verify command in flight at a time,
// with readback/verify response, optional datapath stall and a saturating mismatch count.
`timescale 1ns/1ps
module test_pe_cfg_seq #(
   parameter int STALL_DURING_CFG = 1,
   parameter int ERR_W            = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_en,
   test_pe_cfg_seq_if.slave    bus,
   output logic [7:0]          cfg_a,
   output logic [31:0]         cfg_d,
   output logic                cfg_en,
   input  logic [31:0]         read_data,
   output logic                pe_clk_en,
   output logic [ERR_W-1:0]    err_cnt,
   input  logic                err_clr
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WRITE    = 3'd1;
   localparam logic [2:0] S_RD_SETUP = 3'd2;
   localparam logic [2:0] S_RD_CAP   = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   localparam logic [1:0] OP_WR  = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_WRV = 2'd2;
   localparam logic [1:0] OP_RSV = 2'd3;

   // Narrow PE registers only implement some bits; verify compares just those.
   function automatic logic [31:0] verify_mask(input logic [7:0] a);
      case (a)
         8'hF0, 8'hF1:        verify_mask = 32'h0000_FFFF;
         8'hF3, 8'hF4, 8'hF5: verify_mask = 32'h0000_0001;
         default:             verify_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   logic [2:0]       r_state;
   logic [1:0]       r_op;
   logic [31:0]      r_data;
   logic [7:0]       r_cfg_a;
   logic [31:0]      r_cfg_d;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_err;
   logic [ERR_W-1:0] r_err_cnt;

   logic w_accept;
   logic w_mismatch;
   logic w_stall_en;

   assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
   assign w_mismatch = ((read_data ^ r_data) & verify_mask(r_cfg_a)) != 32'd0;
   assign w_stall_en = (STALL_DURING_CFG != 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= OP_WR;
         r_data     <= 32'd0;
         r_cfg_a    <= 8'd0;
         r_cfg_d    <= 32'd0;
         r_rsp_data <= 32'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op   <= bus.cmd_op;
                  r_data <= bus.cmd_data;
                  // Reserved ops never touch the bus, so the bus lines keep their old values.
                  if (bus.cmd_op != OP_RSV) r_cfg_a <= bus.cmd_addr;
                  if (bus.cmd_op == OP_WR || bus.cmd_op == OP_WRV) r_cfg_d <= bus.cmd_data;
                  case (bus.cmd_op)
                     OP_RD:   r_state <= S_RD_SETUP;
                     OP_RSV: begin
                        r_state    <= S_RESP;
                        r_rsp_data <= 32'd0;
                        r_rsp_err  <= 1'b1;
                     end
                     default: r_state <= S_WRITE;
                  endcase
               end
            end
            S_WRITE: begin
               if (r_op == OP_WRV) begin
                  r_state <= S_RD_SETUP;
               end else begin
                  r_state    <= S_RESP;
                  r_rsp_data <= 32'd0;
                  r_rsp_err  <= 1'b0;
               end
            end
            S_RD_SETUP: r_state <= S_RD_CAP;
            S_RD_CAP: begin
               r_rsp_data <= read_data;
               r_rsp_err  <= (r_op == OP_WRV) && w_mismatch;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Clear takes priority over a coincident mismatch increment.
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         r_err_cnt <= '0;
      end else if (r_state == S_RD_CAP && r_op == OP_WRV && w_mismatch && !(&r_err_cnt)) begin
         r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
   assign cfg_a         = r_cfg_a;
   assign cfg_d         = r_cfg_d;
   assign cfg_en        = (r_state == S_WRITE);
   assign pe_clk_en     = run_en & ~(w_stall_en & (r_state != S_IDLE));
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_test_pe_cfg_seq.sv
// Scoreboard bench for test_pe_cfg_seq: a PE register model on the config bus,
// a command-level reference model feeding an expectation queue, and a response monitor.
`timescale 1ns/1ps
module tb_test_pe_cfg_seq;

   localparam int ERR_W = 2;
   localparam logic [ERR_W-1:0] CNT_MAX = '1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run_en = 1'b1;
   logic [7:0]        cfg_a;
   logic [31:0]       cfg_d;
   logic              cfg_en;
   logic [31:0]       read_data;
   logic              pe_clk_en;
   logic [ERR_W-1:0]  err_cnt;
   logic              err_clr = 1'b0;
   logic [31:0]       flip = 32'd0;

   test_pe_cfg_seq_if bus ();

   test_pe_cfg_seq #(.STALL_DURING_CFG(1), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .bus(bus),
      .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_en(cfg_en), .read_data(read_data),
      .pe_clk_en(pe_clk_en), .err_cnt(err_cnt), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // PE register widths: F0/F1 are 16-bit, F3..F5 single-bit, the rest full width.
   function automatic logic [31:0] pe_store(input logic [7:0] a, input logic [31:0] d);
      case (a)
         8'hF0, 8'hF1:        pe_store = d & 32'h0000_FFFF;
         8'hF3, 8'hF4, 8'hF5: pe_store = d & 32'h0000_0001;
         default:             pe_store = d;
      endcase
   endfunction

   function automatic logic [31:0] ref_mask(input logic [7:0] a);
      if (a == 8'hF0 || a == 8'hF1) ref_mask = 32'h0000_FFFF;
      else if (a >= 8'hF3 && a <= 8'hF5) ref_mask = 32'h0000_0001;
      else ref_mask = 32'hFFFF_FFFF;
   endfunction

   logic [31:0] pe_mem  [256] = '{default: 32'd0};
   logic [31:0] ref_mem [256] = '{default: 32'd0};

   always @(posedge clk) if (cfg_en) pe_mem[cfg_a] <= pe_store(cfg_a, cfg_d);
   assign read_data = pe_mem[cfg_a] ^ flip;

   typedef struct {
      logic [31:0]      d;
      logic             e;
      logic [ERR_W-1:0] c;
   } exp_t;

   exp_t             q[$];
   logic [ERR_W-1:0] m_cnt = '0;
   int               n_tests = 0;
   int               n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: one pop per handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("rsp_data", bus.rsp_data, e.d);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.e});
            chk("err_cnt", {30'd0, err_cnt}, {30'd0, e.c});
         end
      end
   end

   // Reference model: expected response for a command, from the architectural rules.
   task automatic model_push(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      logic [31:0] rd;
      e.d = 32'd0;
      e.e = 1'b0;
      case (op)
         2'd0: ref_mem[a] = pe_store(a, d);
         2'd1: e.d = ref_mem[a] ^ flip;
         2'd2: begin
            ref_mem[a] = pe_store(a, d);
            rd  = ref_mem[a] ^ flip;
            e.d = rd;
            e.e = ((rd ^ d) & ref_mask(a)) != 32'd0;
            if (e.e && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
         end
         default: e.e = 1'b1;
      endcase
      if (err_clr) m_cnt = '0;
      e.c = m_cnt;
      q.push_back(e);
   endtask

   // Issue one command; caller is just after a rising edge. Returns just after the response handshake.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d, input int hold);
      int k;
      int lat;
      int en_cnt;
      int en_first;
      int exp_lat;
      logic [31:0] hdata;
      model_push(op, a, d);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      bus.rsp_ready = (hold == 0);
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (bus.cmd_ready) break;
         k++;
      end
      chk("accept_wait", (k < 20) ? 32'd1 : 32'd0, 32'd1);
      chk("idle_pe_clk_en", {31'd0, pe_clk_en}, {31'd0, run_en});
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_data  = $urandom;
      lat = 0; en_cnt = 0; en_first = 0; k = 0;
      while (lat == 0 && k < 20) begin
         @(negedge clk);
         k++;
         if (cfg_en) begin
            en_cnt++;
            if (en_first == 0) en_first = k;
            chk("cfg_a", {24'd0, cfg_a}, {24'd0, a});
            chk("cfg_d", cfg_d, d);
         end
         if (bus.rsp_valid) lat = k;
         chk("busy_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
         chk("busy_pe_clk_en", {31'd0, pe_clk_en}, 32'd0);
      end
      exp_lat = (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : (op == 2'd2) ? 4 : 1;
      chk("rsp_latency", lat, exp_lat);
      chk("cfg_en_cycles", en_cnt, (op == 2'd0 || op == 2'd2) ? 1 : 0);
      chk("cfg_en_pos", en_first, (op == 2'd0 || op == 2'd2) ? 1 : 0);
      if (lat == 0) return;
      if (hold > 0) begin
         hdata = bus.rsp_data;
         repeat (hold) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_rsp_data", bus.rsp_data, hdata);
            chk("hold_pe_clk_en", {31'd0, pe_clk_en}, 32'd0);
            chk("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
         end
         @(posedge clk);
         #1;
         bus.rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  op;
      logic [7:0]  a;
      logic [31:0] d;
      int          hold;
      int          k;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_addr  = 8'd0;
      bus.cmd_data  = 32'd0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_cfg_a", {24'd0, cfg_a}, 32'd0);
      chk("rst_cfg_d", cfg_d, 32'd0);
      chk("rst_cfg_en", {31'd0, cfg_en}, 32'd0);
      chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      issue(2'd0, 8'hFF, 32'h0203_0001, 0);
      issue(2'd1, 8'hFF, 32'h0, 0);
      flip = 32'd0; issue(2'd2, 8'hF0, 32'hDEAD_1234, 0);
      flip = 32'd1; issue(2'd2, 8'hF0, 32'hDEAD_1234, 0);
      flip = 32'd0; issue(2'd2, 8'hF3, 32'h0000_0003, 0);
      flip = 32'd2; issue(2'd2, 8'h00, 32'h0000_0003, 0);
      flip = 32'd0;
      run_en = 1'b1;
      issue(2'd1, 8'hF0, 32'h0, 5);
      issue(2'd3, 8'h12, 32'hCAFE_F00D, 0);

      // Reset during the read-back settle of a verify aborts it silently.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      bus.cmd_addr  = 8'hF1;
      bus.cmd_data  = 32'h1357_9BDF;
      @(negedge clk);
      chk("abort_accept_ready", {31'd0, bus.cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      ref_mem[8'hF1] = pe_store(8'hF1, 32'h1357_9BDF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_cnt = '0;
      @(negedge clk);
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("abort_cfg_en", {31'd0, cfg_en}, 32'd0);
      chk("abort_cfg_a", {24'd0, cfg_a}, 32'd0);
      chk("abort_cfg_d", cfg_d, 32'd0);
      chk("abort_rsp_data", bus.rsp_data, 32'd0);
      chk("abort_err_cnt", {30'd0, err_cnt}, 32'd0);
      @(posedge clk);
      #1;
      issue(2'd0, 8'h55, 32'hA5A5_0F0F, 0);
      issue(2'd1, 8'h55, 32'h0, 0);
      issue(2'd1, 8'hF1, 32'h0, 0);

      flip = 32'd1;
      for (int i = 0; i < 5; i++) issue(2'd2, 8'h20, $urandom, 0);
      chk("sat_err_cnt", {30'd0, err_cnt}, {30'd0, CNT_MAX});
      err_clr = 1'b1;
      issue(2'd2, 8'h21, $urandom, 0);
      err_clr = 1'b0;
      chk("clr_err_cnt", {30'd0, err_cnt}, 32'd0);
      flip = 32'd0;

      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = 8'hF0 + 8'($urandom_range(0, 5));
            1:       a = 8'($urandom_range(0, 3));
            2:       a = 8'hFF;
            default: a = 8'($urandom);
         endcase
         d = $urandom;
         flip = ($urandom_range(0, 1) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'd1 : $urandom);
         run_en = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         issue(op, a, d, hold);
      end

      k = 0;
      while (q.size() != 0 && k < 50) begin
         @(posedge clk);
         k++;
      end
      chk("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/test_pe_cfg_seq.md
Name: test_pe_cfg_seq

Overview:
Configuration sequencer for the PE tile's shared config bus (cfg_a/cfg_d/cfg_en/read_data). It accepts write, read and write-verify commands over a valid/ready command channel and drives them onto the bus one at a time. It returns readback data and verify status over a valid/ready response channel. It can stall the PE datapath through clk_en while a command is in flight, and it sits between the tile config network and the PE.

Parameters:
STALL_DURING_CFG, 1, when 1 pe_clk_en is forced low while the sequencer is not IDLE
ERR_W, 8, width of saturating verify-mismatch counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run_en  in  1  datapath run enable from tile control
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_op  in  2  0=write, 1=read, 2=write+verify, 3=reserved
cmd_addr  in  8  config address
cmd_data  in  32  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  32  readback data (0 for plain write)
rsp_err  out  1  verify mismatch or reserved op
cfg_a  out  8  to PE cfg_a
cfg_d  out  32  to PE cfg_d
cfg_en  out  1  to PE cfg_en
read_data  in  32  from PE read_data (combinational on cfg_a)
pe_clk_en  out  1  to PE clk_en
err_cnt  out  ERR_W  saturating verify-mismatch count
err_clr  in  1  clear err_cnt

Behaviour:
- Reset (sync, active-high): state=IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; cfg_a=0; cfg_d=0; cfg_en=0; err_cnt=0. Reset asserted mid-command aborts it with no response; cfg_en=0 from the next edge.
- States: IDLE, WRITE, RD_SETUP, RD_CAP, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/addr/data. Next state: op0/op2 -> WRITE, op1 -> RD_SETUP, op3 -> RESP with rsp_data=0, rsp_err=1.
- cmd_ready=1 only in IDLE. Exactly one command is outstanding at a time.
- WRITE: exactly one cycle with cfg_en=1, cfg_a=addr, cfg_d=data. Next state: op0 -> RESP with rsp_data=0, rsp_err=0; op2 -> RD_SETUP.
- RD_SETUP: cfg_en=0, cfg_a=addr held for one settle cycle.
- RD_CAP: capture rsp_data=read_data.
  - op1: rsp_err=0.
  - op2: rsp_err=((read_data^data)&mask)!=0.
  - mask by addr: 8'hF0/8'hF1 -> 32'h0000FFFF; 8'hF3/F4/F5 -> 32'h00000001; all others -> 32'hFFFFFFFF.
  - Next state: RESP.
- RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_valid&rsp_ready, then IDLE.
- Latency from accept edge N: write rsp_valid at N+2 (cfg_en at N+1); read capture at N+2, rsp_valid at N+3; verify cfg_en at N+1, rsp_valid at N+4; reserved rsp_valid at N+1.
- cfg_en is high only in WRITE. cfg_a/cfg_d hold their last values outside WRITE/RD_*.
- pe_clk_en = run_en & ~(STALL_DURING_CFG & (state!=IDLE)), combinational from registered state.
- err_cnt increments by 1 in RD_CAP when op2 mismatches, saturating at 2^ERR_W-1.
  - err_clr clears err_cnt; clear wins over a same-cycle increment.
- Back-to-back: with rsp_ready held high, the next command is accepted the cycle after RESP completes. There is no accept during RESP.

Test Plan:
- Write 8'hFF/32'h0203_0001 (op0), rsp_ready=1 -> cfg_en high exactly one cycle with cfg_a=8'hFF, cfg_d=32'h02030001; rsp_valid at N+2, rsp_data=0, rsp_err=0; later read of 8'hFF returns 32'h02030001.
- Verify 8'hF0/32'hDEAD_1234 (op2) with PE read_data returning 32'h0000_1234 -> rsp_err=0, rsp_data=32'h00001234, err_cnt unchanged; bench model forcing read_data=32'h0000_1235 -> rsp_err=1, err_cnt=1.
- Verify 8'hF3/32'h0000_0003 with read_data=1 -> rsp_err=0 (mask bit0); the same data to 8'h00 with read_data=1 -> rsp_err=1.
- run_en=1, STALL_DURING_CFG=1, read command -> pe_clk_en low from N+1 through the RESP cycle; rsp_ready held low for 5 cycles -> rsp_valid, rsp_data and pe_clk_en=0 all held; cmd_ready=0 throughout.
- op3 -> rsp_valid at N+1, rsp_err=1, cfg_en never asserted; err_cnt unchanged.
- rst pulsed during RD_SETUP of a verify -> no response; all outputs at reset values the next cycle; next write completes normally. With ERR_W=2, 5 mismatches -> err_cnt=3; err_clr coinciding with a mismatch -> err_cnt=0.
